// File: rtl/mcpu_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// mcpu_ctrl_fsm_pkg
//   Shared definitions for the multi-cycle MIPS control FSM:
//   - state codes (also exported to the DBU as a raw number)
//   - opcode constants for the supported instructions
//   - ALU operation, ALU-B select and PC-source select codes
//   - the packed control vector produced by the state decoder
//   - a helper that tells whether an opcode is in the supported set
// -----------------------------------------------------------------------------
package mcpu_ctrl_fsm_pkg;

  // State encoding. The numeric values are visible to the DBU display, so
  // they are fixed explicitly rather than left to the tool.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_ADR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_R_EX    = 4'd7,
    S_R_WB    = 4'd8,
    S_I_EX    = 4'd9,
    S_I_WB    = 4'd10,
    S_BEQ     = 4'd11,
    S_JUMP    = 4'd12
  } state_e;

  // Opcodes (IR[31:26]) of the supported instructions.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation requested from the ALU control block.
  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_SUB   = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

  // ALU B-input mux selects.
  localparam logic [1:0] ALUB_B       = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

  // PC source mux selects.
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Every datapath control driven by the FSM, in one packed bundle so the
  // decoder has a single output and a default of '0 clears everything.
  typedef struct packed {
    logic       pc_we;
    logic       pc_wec;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_we;
    logic       ir_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       rf_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  // True for opcodes the FSM knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J)  || (op == OP_BEQ) ||
           (op == OP_ADDI)  || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mcpu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mcpu_ctrl_decode
//   Purely combinational state -> control-vector decoder for the multi-cycle
//   MIPS control FSM. Every control not explicitly set in a state is 0.
// Ports
//   st       in   state_e  current FSM state
//   opcode   in   6        IR[31:26]; only consulted in DECODE for illegal
//   ctrl     out  ctrl_t   datapath mux selects and write enables
//   illegal  out  1        unsupported opcode seen in DECODE
// -----------------------------------------------------------------------------
module mcpu_ctrl_decode
  import mcpu_ctrl_fsm_pkg::*;
(
  input  state_e     st,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (st)
      S_FETCH: begin
        // Read instruction at PC into IR and compute PC+4 into PC.
        ctrl.i_or_d    = 1'b0;
        ctrl.ir_we     = 1'b1;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.pc_we     = 1'b1;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUB_IMM_SH2;
        ctrl.alu_op    = ALU_OP_ADD;
        // An unsupported opcode retires here as a NOP.
        if (!op_supported(opcode)) begin
          illegal         = 1'b1;
          ctrl.instr_done = 1'b1;
        end
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        ctrl.i_or_d = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
        ctrl.rf_we      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.i_or_d     = 1'b1;
        ctrl.mem_we     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_R_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_B;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.rf_we      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_I_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_I_WB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.rf_we      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        // A - B via subtract; PC takes ALUOut (target) only if zero.
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = ALUB_B;
        ctrl.alu_op     = ALU_OP_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.pc_wec     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_we      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: begin
        // IDLE and unused codes drive nothing.
        ctrl    = '0;
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mcpu_ctrl_fsm
//   Main control FSM of the multi-cycle MIPS CPU. Sequences the shared
//   datapath over 3-5 cycles per instruction. Moore machine: the state is the
//   only register; every output is a decode of the state (illegal also looks
//   at the opcode in DECODE).
//
//   run handshake: run is a level enable from the DBU, not a valid/ready pair.
//   It is only sampled at an instruction boundary (IDLE, or the cycle where
//   instr_done is high). Dropping run mid-instruction lets the instruction
//   finish, so the datapath never sees a partial set of writes.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   run                   DBU execute enable
//   opcode [OPW]          IR[31:26]
//   zero                  ALU zero flag; the conditional PC write is gated
//                         by it in the datapath, not here
//   pc_we .. alu_op       datapath controls (see mcpu_ctrl_fsm_pkg::ctrl_t)
//   instr_done            pulse on the last cycle of each instruction
//   illegal               pulse in DECODE for an unsupported opcode
//   state [STW]           current state code, for DBU display
// -----------------------------------------------------------------------------
module mcpu_ctrl_fsm
  import mcpu_ctrl_fsm_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           pc_we,
  output logic           pc_wec,
  output logic [1:0]     pc_src,
  output logic           i_or_d,
  output logic           mem_we,
  output logic           ir_we,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           rf_we,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic           instr_done,
  output logic           illegal,
  output logic [STW-1:0] state
);

  state_e     cur_state;
  state_e     nxt_state;
  state_e     boundary;
  logic [5:0] op;
  ctrl_t      ctrl;

  assign op = 6'(opcode);

  // zero is consumed by the datapath PC-write gate (pc_wec & zero); the
  // sequencing itself does not depend on it.
  logic unused_zero;
  assign unused_zero = zero;

  // Where to go after the last cycle of any instruction.
  assign boundary = run ? S_FETCH : S_IDLE;

  always_comb begin
    nxt_state = S_IDLE;
    case (cur_state)
      S_IDLE:   nxt_state = run ? S_FETCH : S_IDLE;
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW) nxt_state = S_MEM_ADR;
        else if (op == OP_RTYPE)        nxt_state = S_R_EX;
        else if (op == OP_ADDI)         nxt_state = S_I_EX;
        else if (op == OP_BEQ)          nxt_state = S_BEQ;
        else if (op == OP_J)            nxt_state = S_JUMP;
        else                            nxt_state = boundary;
      end
      // IR is stable from DECODE on, so only lw/sw reach here; anything
      // other than sw is treated as a load.
      S_MEM_ADR: nxt_state = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  nxt_state = S_MEM_WB;
      S_MEM_WB:  nxt_state = boundary;
      S_MEM_WR:  nxt_state = boundary;
      S_R_EX:    nxt_state = S_R_WB;
      S_R_WB:    nxt_state = boundary;
      S_I_EX:    nxt_state = S_I_WB;
      S_I_WB:    nxt_state = boundary;
      S_BEQ:     nxt_state = boundary;
      S_JUMP:    nxt_state = boundary;
      // Unused codes 13-15 recover to IDLE.
      default:   nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cur_state <= S_IDLE;
    else        cur_state <= nxt_state;
  end

  mcpu_ctrl_decode u_decode (
    .st      (cur_state),
    .opcode  (op),
    .ctrl    (ctrl),
    .illegal (illegal)
  );

  assign pc_we      = ctrl.pc_we;
  assign pc_wec     = ctrl.pc_wec;
  assign pc_src     = ctrl.pc_src;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_we     = ctrl.mem_we;
  assign ir_we      = ctrl.ir_we;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign rf_we      = ctrl.rf_we;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign instr_done = ctrl.instr_done;
  assign state      = STW'(cur_state);

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mcpu_ctrl_fsm
//   Table of per-cycle {inputs, expected state} records; each applied cycle
//   compares the state code and the full output vector against the control
//   table for that state. Hand-written sequences cover the run pulse and the
//   jump latency.
// -----------------------------------------------------------------------------
module tb_mcpu_ctrl_fsm;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;

  logic       pc_we, pc_wec, i_or_d, mem_we, ir_we, reg_dst, mem_to_reg;
  logic       rf_we, alu_src_a, instr_done, illegal;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  mcpu_ctrl_fsm #(.OPW(6), .STW(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .pc_we(pc_we), .pc_wec(pc_wec), .pc_src(pc_src), .i_or_d(i_or_d),
    .mem_we(mem_we), .ir_we(ir_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .rf_we(rf_we), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [17:0] exp_q[$];

  // Output vector order:
  // {pc_we,pc_wec,pc_src[1:0],i_or_d,mem_we,ir_we,reg_dst,mem_to_reg,rf_we,
  //  alu_src_a,alu_src_b[1:0],alu_op[1:0],instr_done,illegal}
  function automatic logic [17:0] spec_out(input int st, input logic [5:0] op);
    logic [17:0] v;
    logic ok;
    ok = (op == LW) || (op == SW) || (op == RT) || (op == ADDI) ||
         (op == BEQ) || (op == JMP);
    case (st)
      1:  v = {1'b1,1'b0,2'd0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,1'b0,1'b0};
      2:  v = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd0,!ok,!ok};
      3:  v = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,1'b0,1'b0};
      4:  v = {1'b0,1'b0,2'd0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0};
      5:  v = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,1'b1,1'b0};
      6:  v = {1'b0,1'b0,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,1'b0};
      7:  v = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd2,1'b0,1'b0};
      8:  v = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,1'b1,1'b0};
      9:  v = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,1'b0,1'b0};
      10: v = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,2'd0,1'b1,1'b0};
      11: v = {1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd1,1'b1,1'b0};
      12: v = {1'b1,1'b0,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [17:0] act_out();
    return {pc_we, pc_wec, pc_src, i_or_d, mem_we, ir_we, reg_dst, mem_to_reg,
            rf_we, alu_src_a, alu_src_b, alu_op, instr_done, illegal};
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare state, the whole output vector and write-enable exclusivity.
  task automatic check_cycle(input string tag, input int exp_state);
    logic [17:0] exp_v;
    logic [17:0] got_v;
    int n_we;
    exp_q.push_back(spec_out(exp_state, opcode));
    exp_v = exp_q.pop_front();
    got_v = act_out();
    check_int({tag, " state"}, int'(state), exp_state);
    tests++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL %s outputs (state %0d): got %05h expected %05h",
               tag, exp_state, got_v, exp_v);
    end
    n_we = int'(mem_we) + int'(rf_we) + int'(pc_we) + int'(ir_we);
    if (int'(state) != 1)
      check_int({tag, " we_excl"}, (n_we > 1) ? 1 : 0, 0);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic rn, input logic [5:0] op,
                       input logic z);
    @(negedge clk);
    rst_n  = r;
    run    = rn;
    opcode = op;
    zero   = z;
  endtask

  typedef struct {
    logic       rst_n;
    logic       run;
    logic [5:0] opcode;
    logic       zero;
    int         exp_state;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic rn, input logic [5:0] op,
                              input logic z, input int es, input string tag);
    vec_t v;
    v.rst_n = r; v.run = rn; v.opcode = op; v.zero = z;
    v.exp_state = es; v.tag = tag;
    vecs.push_back(v);
  endfunction

  int done_cnt;
  int rfwe_state;
  int cyc;
  bit seen;

  initial begin
    // reset, then idle with run low
    add(0, 0, RT, 0, 0, "rst");
    add(0, 0, RT, 0, 0, "rst");
    for (int i = 0; i < 5; i++) add(1, 0, RT, 0, 0, "idle");
    // lw: 1,2,3,4,5 then back to FETCH
    add(1, 1, LW, 0, 1, "lw"); add(1, 1, LW, 0, 2, "lw");
    add(1, 1, LW, 0, 3, "lw"); add(1, 1, LW, 0, 4, "lw");
    add(1, 1, LW, 0, 5, "lw"); add(1, 1, LW, 0, 1, "lw");
    // sw then R-type
    add(1, 1, SW, 0, 2, "sw"); add(1, 1, SW, 0, 3, "sw");
    add(1, 1, SW, 0, 6, "sw"); add(1, 1, SW, 0, 1, "sw");
    add(1, 1, RT, 0, 2, "rtype"); add(1, 1, RT, 0, 7, "rtype");
    add(1, 1, RT, 0, 8, "rtype"); add(1, 1, RT, 0, 1, "rtype");
    // beq with zero=1, then j
    add(1, 1, BEQ, 1, 2, "beq"); add(1, 1, BEQ, 1, 11, "beq");
    add(1, 1, BEQ, 1, 1, "beq");
    add(1, 1, JMP, 0, 2, "j"); add(1, 1, JMP, 0, 12, "j");
    add(1, 1, JMP, 0, 1, "j");
    // illegal opcode: retires in DECODE, then FETCH
    add(1, 1, BAD, 0, 2, "illegal"); add(1, 1, BAD, 0, 1, "illegal");
    // run dropped while in MEM_RD: finish lw, then IDLE
    add(1, 1, LW, 0, 2, "lw_stop"); add(1, 1, LW, 0, 3, "lw_stop");
    add(1, 1, LW, 0, 4, "lw_stop"); add(1, 0, LW, 0, 5, "lw_stop");
    add(1, 0, LW, 0, 0, "lw_stop"); add(1, 0, LW, 0, 0, "lw_stop");
    // reset in R_EX: IDLE next edge, no rf_we
    add(1, 1, RT, 0, 1, "r_rst"); add(1, 1, RT, 0, 2, "r_rst");
    add(1, 1, RT, 0, 7, "r_rst"); add(0, 1, RT, 0, 0, "r_rst");
    add(1, 0, RT, 0, 0, "r_rst");

    done_cnt = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].run, vecs[i].opcode, vecs[i].zero);
      @(posedge clk); #1;
      check_cycle(vecs[i].tag, vecs[i].exp_state);
      if (vecs[i].tag == "lw" && instr_done) done_cnt++;
    end
    check_int("lw instr_done count", done_cnt, 1);

    // run pulsed for one cycle around an addi: runs to completion, then IDLE
    done_cnt = 0;
    rfwe_state = -1;
    drive(1, 1, ADDI, 0);
    @(posedge clk); #1;
    check_cycle("addi_pulse", 1);
    drive(1, 0, ADDI, 0);
    @(posedge clk); #1; check_cycle("addi_pulse", 2);
    @(posedge clk); #1; check_cycle("addi_pulse", 9);
    if (rf_we) rfwe_state = int'(state);
    @(posedge clk); #1; check_cycle("addi_pulse", 10);
    if (rf_we) rfwe_state = int'(state);
    if (instr_done) done_cnt++;
    @(posedge clk); #1; check_cycle("addi_pulse", 0);
    check_int("addi rf_we state", rfwe_state, 10);
    check_int("addi instr_done count", done_cnt, 1);

    // jump latency from IDLE: instr_done on the 3rd cycle, bounded wait
    drive(1, 1, JMP, 0);
    seen = 0;
    cyc = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(posedge clk); #1;
      if (instr_done) begin
        seen = 1;
        cyc = c;
      end
    end
    if (!seen) check_int("j instr_done timeout", 0, 1);
    else begin
      check_int("j latency", cyc, 3);
      check_int("j done state", int'(state), 12);
      check_int("j pc_src", int'(pc_src), 2);
    end
    drive(1, 0, JMP, 0);
    @(posedge clk); #1;
    check_int("j then idle", int'(state), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
